scroll_sequencer: RTL and testbench

//   Sequencer for the falling-note scrolling datapath. Each scroll tick it advances the
//   4-stage scancode shift chain, loads a new random letter, then refreshes and redraws
//   the 4 note rows one at a time, handshaking finish_update/draw_done. Sits between the

---
 rtl/scroll_pkg.sv | 33 +++
 rtl/scroll_tick_gen.sv | 43 ++++
 rtl/scroll_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_scroll_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// scroll_pkg: shared state encoding and row constants for the scroll sequencer.
// Rev 1.0
// ============================================================================
package scroll_pkg;

  localparam int NUM_ROWS = 4;
  localparam int ROW_W    = 2;

  typedef logic [ROW_W-1:0] row_idx_t;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WAIT_TICK = 4'd1,
    SHIFT3    = 4'd2,
    SHIFT2    = 4'd3,
    SHIFT1    = 4'd4,
    LOAD      = 4'd5,
    RESTART   = 4'd6,
    UPDATE    = 4'd7,
    DRAW      = 4'd8,
    DONE      = 4'd9
  } scroll_state_e;

  function automatic logic [NUM_ROWS-1:0] row_onehot(input row_idx_t r);
    return NUM_ROWS'(1) << r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scroll_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// scroll_tick_gen: divides clk by TICK_CYCLES while enabled, one-cycle tick on wrap.
// Rev 1.0
// ============================================================================
module scroll_tick_gen #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/scroll_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// scroll_sequencer: per-tick shift/load then 4-row update/draw handshake sequencer.
// Optional feature macro: SCROLL_TIMEOUT_EN (handshake timeout).   Rev 1.0
// ============================================================================
module scroll_sequencer
  import scroll_pkg::*;
#(
  parameter int TICK_CYCLES    = 25_000_000,
  parameter int UPDATE_TIMEOUT = 4095
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       finish_update_i,
  input  logic       draw_done_i,
  output logic       load_o,
  output logic       shift1_o,
  output logic       shift2_o,
  output logic       shift3_o,
  output logic       restart_o,
  output logic       update_o,
  output logic       wren1_o,
  output logic       wren2_o,
  output logic       wren3_o,
  output logic       wren4_o,
  output logic       draw1_o,
  output logic       draw2_o,
  output logic       draw3_o,
  output logic       draw4_o,
  output logic       busy_o,
  output logic [7:0] scroll_count_o,
  output logic       overrun_o,
  output logic       timeout_err_o
);

  localparam row_idx_t ROW_LAST = row_idx_t'(NUM_ROWS - 1);

  scroll_state_e         state_q, state_d;
  row_idx_t              row_q, row_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            count_q, count_d;
  logic                  shift3_q, shift2_q, shift1_q, load_q, restart_q, update_q, busy_q;
  logic                  shift3_d, shift2_d, shift1_d, load_d, restart_d, update_d, busy_d;
  logic [NUM_ROWS-1:0]   wren_q, wren_d, draw_q, draw_d;
  logic                  tick;
  logic                  consume;
  logic                  clr_pending;
  logic                  hs_timeout;

  scroll_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .tick_o   (tick)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    count_d     = count_q;
    consume     = 1'b0;
    clr_pending = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable_i) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable_i) begin
          state_d     = IDLE;
          clr_pending = 1'b1;
        end else if (pending_q) begin
          state_d = SHIFT3;
          consume = 1'b1;
        end
      end
      // Deepest stage moves first so nothing is overwritten before it advances.
      SHIFT3:  state_d = SHIFT2;
      SHIFT2:  state_d = SHIFT1;
      SHIFT1:  state_d = LOAD;
      LOAD:    state_d = RESTART;
      RESTART: state_d = UPDATE;
      UPDATE: begin
        if (finish_update_i || hs_timeout) state_d = DRAW;
      end
      DRAW: begin
        if (draw_done_i || hs_timeout) begin
          if (row_q == ROW_LAST) begin
            state_d = DONE;
            row_d   = '0;
            count_d = count_q + 8'd1;
          end else begin
            state_d = RESTART;
            row_d   = row_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (enable_i) begin
          state_d = WAIT_TICK;
        end else begin
          state_d     = IDLE;
          clr_pending = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    shift3_d  = (state_d == SHIFT3);
    shift2_d  = (state_d == SHIFT2);
    shift1_d  = (state_d == SHIFT1);
    load_d    = (state_d == LOAD);
    restart_d = (state_d == RESTART);
    update_d  = (state_d == UPDATE);
    wren_d    = (state_d == UPDATE) ? row_onehot(row_d) : '0;
    draw_d    = (state_d == DRAW)   ? row_onehot(row_d) : '0;
    busy_d    = (state_d != IDLE) && (state_d != WAIT_TICK);

    pending_d = clr_pending ? 1'b0 : ((pending_q && !consume) || tick);
    overrun_d = overrun_q || (tick && pending_q && !consume);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      row_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
      shift3_q  <= 1'b0;
      shift2_q  <= 1'b0;
      shift1_q  <= 1'b0;
      load_q    <= 1'b0;
      restart_q <= 1'b0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
      wren_q    <= '0;
      draw_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
      shift3_q  <= shift3_d;
      shift2_q  <= shift2_d;
      shift1_q  <= shift1_d;
      load_q    <= load_d;
      restart_q <= restart_d;
      update_q  <= update_d;
      busy_q    <= busy_d;
      wren_q    <= wren_d;
      draw_q    <= draw_d;
    end
  end

`ifdef SCROLL_TIMEOUT_EN
  localparam int TO_W = $clog2(UPDATE_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic            in_handshake;
  logic            handshake;

  assign in_handshake = (state_q == UPDATE) || (state_q == DRAW);
  assign handshake    = (state_q == UPDATE) ? finish_update_i : draw_done_i;
  assign hs_timeout   = in_handshake && !handshake &&
                        (to_cnt_q == TO_W'(UPDATE_TIMEOUT - 1));

  always_comb begin
    to_cnt_d      = '0;
    timeout_err_d = timeout_err_q || hs_timeout;
    if (in_handshake && (state_d == state_q)) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^UPDATE_TIMEOUT;
  assign hs_timeout         = 1'b0;
  assign timeout_err_o      = 1'b0;
`endif

  assign shift3_o       = shift3_q;
  assign shift2_o       = shift2_q;
  assign shift1_o       = shift1_q;
  assign load_o         = load_q;
  assign restart_o      = restart_q;
  assign update_o       = update_q;
  assign {wren4_o, wren3_o, wren2_o, wren1_o} = wren_q;
  assign {draw4_o, draw3_o, draw2_o, draw1_o} = draw_q;
  assign busy_o         = busy_q;
  assign scroll_count_o = count_q;
  assign overrun_o      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_scroll_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_scroll_sequencer: directed scenarios with a strobe-event scoreboard.
// Define SCROLL_TIMEOUT_EN to also exercise the handshake timeout.   Rev 1.0
// ============================================================================
module tb_scroll_sequencer;

  localparam int TICK = 64;
  localparam int TOUT = 16;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic       finish_update_i;
  logic       draw_done_i;
  logic       load_o, shift1_o, shift2_o, shift3_o, restart_o, update_o;
  logic       wren1_o, wren2_o, wren3_o, wren4_o;
  logic       draw1_o, draw2_o, draw3_o, draw4_o;
  logic       busy_o, overrun_o, timeout_err_o;
  logic [7:0] scroll_count_o;

  scroll_sequencer #(
    .TICK_CYCLES    (TICK),
    .UPDATE_TIMEOUT (TOUT)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .finish_update_i (finish_update_i),
    .draw_done_i     (draw_done_i),
    .load_o          (load_o),
    .shift1_o        (shift1_o),
    .shift2_o        (shift2_o),
    .shift3_o        (shift3_o),
    .restart_o       (restart_o),
    .update_o        (update_o),
    .wren1_o         (wren1_o),
    .wren2_o         (wren2_o),
    .wren3_o         (wren3_o),
    .wren4_o         (wren4_o),
    .draw1_o         (draw1_o),
    .draw2_o         (draw2_o),
    .draw3_o         (draw3_o),
    .draw4_o         (draw4_o),
    .busy_o          (busy_o),
    .scroll_count_o  (scroll_count_o),
    .overrun_o       (overrun_o),
    .timeout_err_o   (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Event codes: 1 shift3, 2 shift2, 3 shift1, 4 load, 5 restart,
  // 6..9 wren1..4 rising, 10..13 draw1..4 rising, 15 scroll_count increment.
  int          exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          first_sh3 = 0;
  int          resp_delay = 3;
  bit          hold_hs = 1'b0;
  int          upd_run = 0;
  int          drw_run = 0;
  int          upd_cycles = 0;
  int          drw_cycles = 0;
  logic [12:0] prev_v = '0;
  logic [7:0]  prev_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_event(input int code);
    int e;
    check("sb_event_expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_event_order", code, e);
    end
  endtask

  task automatic push_seq(input int rows, input bit with_done);
    for (int k = 1; k <= 4; k++) exp_q.push_back(k);
    for (int r = 0; r < rows; r++) begin
      exp_q.push_back(5);
      exp_q.push_back(6 + r);
      exp_q.push_back(10 + r);
    end
    if (with_done) exp_q.push_back(15);
  endtask

  function automatic logic [12:0] strobes();
    return {draw4_o, draw3_o, draw2_o, draw1_o, wren4_o, wren3_o, wren2_o, wren1_o,
            restart_o, load_o, shift1_o, shift2_o, shift3_o};
  endfunction

  // One clock: sample outputs after the edge, score events, then respond.
  task automatic step();
    logic [12:0] now;
    @(posedge clk_i);
    #1;
    cyc++;
    now = strobes();
    for (int b = 0; b < 13; b++) begin
      if (now[b] && !prev_v[b]) sb_event(b + 1);
    end
    if (scroll_count_o == prev_cnt + 8'd1) sb_event(15);
    if (first_sh3 == 0 && now[0]) first_sh3 = cyc;
    if (update_o) upd_cycles++;
    if (|now[12:9]) drw_cycles++;
    check("wren_draw_onehot", 32'($onehot0(now[12:5])), 1);
    prev_v   = now;
    prev_cnt = scroll_count_o;
    if (hold_hs) begin
      finish_update_i = 1'b1;
      draw_done_i     = 1'b1;
    end else begin
      upd_run         = update_o ? upd_run + 1 : 0;
      drw_run         = (|now[12:9]) ? drw_run + 1 : 0;
      finish_update_i = update_o && (upd_run == resp_delay);
      draw_done_i     = (|now[12:9]) && (drw_run == resp_delay);
    end
  endtask

  task automatic apply_reset();
    enable_i        = 1'b0;
    reset_i         = 1'b1;
    hold_hs         = 1'b0;
    finish_update_i = 1'b0;
    draw_done_i     = 1'b0;
    step();
    step();
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    reset_i    = 1'b0;
    cyc        = 0;
    first_sh3  = 0;
    upd_cycles = 0;
    drw_cycles = 0;
  endtask

  task automatic wait_count(input logic [7:0] target, input int budget, input string tag);
    int n = 0;
    while (scroll_count_o !== target && n < budget) begin
      step();
      n++;
    end
    check(tag, scroll_count_o, target);
  endtask

  function automatic logic [31:0] all_outputs();
    return {strobes(), update_o, busy_o, scroll_count_o, overrun_o, timeout_err_o};
  endfunction

  initial begin
    reset_i         = 1'b1;
    enable_i        = 1'b0;
    finish_update_i = 1'b0;
    draw_done_i     = 1'b0;

    // Reset state, then a normal sequence with 3-cycle handshakes.
    apply_reset();
    check("reset_outputs", all_outputs(), 0);
    resp_delay = 3;
    enable_i   = 1'b1;
    push_seq(4, 1'b1);
    wait_count(8'd1, 300, "t1_count");
    check("t1_first_shift3_cycle", first_sh3, 65);
    check("t1_busy_in_done", busy_o, 1);
    step();
    check("t1_idle_wait_busy", busy_o, 0);
    check("t1_no_overrun", overrun_o, 0);

    // Slow handshakes: ticks pile up, overrun flags, one extra sequence runs.
    apply_reset();
    resp_delay = 40;
    enable_i   = 1'b1;
    push_seq(4, 1'b1);
    push_seq(4, 1'b1);
    wait_count(8'd1, 1000, "t2_first_done");
    check("t2_overrun", overrun_o, 1);
    step();
    step();
    check("t2_pending_restarts", shift3_o, 1);
    enable_i   = 1'b0;
    resp_delay = 3;
    wait_count(8'd2, 300, "t2_second_done");
    repeat (150) step();
    check("t2_no_third_seq", scroll_count_o, 2);
    check("t2_idle", busy_o, 0);
    check("t2_overrun_sticky", overrun_o, 1);

    // Handshakes held high: one cycle per UPDATE/DRAW, no row skipped.
    apply_reset();
    hold_hs = 1'b1;
    enable_i = 1'b1;
    push_seq(4, 1'b1);
    wait_count(8'd1, 300, "t3_count");
    check("t3_update_cycles", upd_cycles, 4);
    check("t3_draw_cycles", drw_cycles, 4);

    // Enable drop during row 2 update: sequence finishes, then idles.
    apply_reset();
    resp_delay = 3;
    enable_i   = 1'b1;
    push_seq(4, 1'b1);
    begin
      int n = 0;
      while (wren2_o !== 1'b1 && n < 200) begin
        step();
        n++;
      end
    end
    check("t4_reached_row2", wren2_o, 1);
    enable_i = 1'b0;
    wait_count(8'd1, 200, "t4_count");
    repeat (100) step();
    check("t4_stays_at_one", scroll_count_o, 1);
    check("t4_idle", busy_o, 0);
    check("t4_timeout_err_off", timeout_err_o, 0);

    // Async reset during row 3 draw; afterwards row 1 runs first.
    apply_reset();
    resp_delay = 3;
    enable_i   = 1'b1;
    push_seq(3, 1'b0);
    begin
      int n = 0;
      while (draw3_o !== 1'b1 && n < 300) begin
        step();
        n++;
      end
    end
    check("t5_reached_draw3", draw3_o, 1);
    #2 reset_i = 1'b1;
    #1;
    check("t5_async_clear", all_outputs(), 0);
    apply_reset();
    enable_i = 1'b1;
    push_seq(4, 1'b1);
    wait_count(8'd1, 300, "t5_count_after_reset");
    check("t5_first_shift3_cycle", first_sh3, 65);

`ifdef SCROLL_TIMEOUT_EN
    // Unanswered update times out after TOUT cycles and moves to DRAW.
    apply_reset();
    resp_delay = 1000;
    enable_i   = 1'b1;
    push_seq(1, 1'b0);
    begin
      int n = 0;
      int n_upd = 0;
      while (update_o !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      check("t6_update_seen", update_o, 1);
      n = 0;
      while (draw1_o !== 1'b1 && n < 100) begin
        if (update_o) n_upd++;
        step();
        n++;
      end
      check("t6_update_cycles", n_upd, TOUT);
      check("t6_draw_entered", draw1_o, 1);
      check("t6_timeout_err", timeout_err_o, 1);
    end
`endif

    apply_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
